// File: rtl/sha256_nonce_dispatcher_pkg.sv
// Shared constants and types for the SHA-256 nonce dispatcher and K sequencer.
// The end-of-range feature is enabled by defining SHA256_DISPATCH_RANGE_EN.
package sha256_nonce_dispatcher_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [31:0] PAD_ONE = 32'h80000000;
    localparam logic [31:0] PAD_LEN = 32'h00000280;

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Transform input: {W[511:0], state[255:0]} with the fixed 80-byte header padding.
    function automatic logic [767:0] build_block(input logic [255:0] mid,
                                                 input logic [95:0]  tail,
                                                 input logic [31:0]  nonce);
        return {PAD_LEN, 320'd0, PAD_ONE, nonce, tail, mid};
    endfunction

endpackage

// File: rtl/sha256_k_sequencer.sv
// Round-constant slice selector: presents the K words used during one unrolled phase.
// The MSB word is K[phase*words_per_phase], followed by successive words.
module sha256_k_sequencer
    import sha256_nonce_dispatcher_pkg::*;
#(
    parameter int P_UNWRAP_LEVEL = 32,
    parameter int PH_W = (P_UNWRAP_LEVEL > 1) ? $clog2(P_UNWRAP_LEVEL) : 1
) (
    input  logic [PH_W-1:0]                 phase_i,
    output logic [2048/P_UNWRAP_LEVEL-1:0]  ks_o
);

    localparam int WORDS = 64 / P_UNWRAP_LEVEL;

    logic [5:0] idx;

    always_comb begin
        ks_o = '0;
        idx  = '0;
        for (int i = 0; i < WORDS; i++) begin
            idx = 6'(int'(phase_i) * WORDS + i);
            ks_o[(WORDS-1-i)*32 +: 32] = K_TABLE[idx];
        end
    end

endmodule

// File: rtl/sha256_nonce_dispatcher.sv
// Issues one SHA-256 block per P_UNWRAP_LEVEL cycles, sweeping the nonce of a loaded job.
// Define SHA256_DISPATCH_RANGE_EN to stop at the job's end nonce and pulse o_done.
module sha256_nonce_dispatcher
    import sha256_nonce_dispatcher_pkg::*;
#(
    parameter int P_UNWRAP_LEVEL = 32
) (
    input  logic                            i_clk,
    input  logic                            i_reset_sync,
    input  logic                            i_work_stb,
    input  logic [255:0]                    i_work_midstate,
    input  logic [95:0]                     i_work_tail,
    input  logic [31:0]                     i_work_nonce_start,
    input  logic [31:0]                     i_work_nonce_end,
    output logic                            o_master_write_stb,
    output logic [767:0]                    o_master_write_data,
    output logic [2048/P_UNWRAP_LEVEL-1:0]  Ks,
    output logic [31:0]                     o_last_nonce,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int L_KS_W = 2048 / P_UNWRAP_LEVEL;
    localparam int PH_W   = (P_UNWRAP_LEVEL > 1) ? $clog2(P_UNWRAP_LEVEL) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(P_UNWRAP_LEVEL - 1);

    state_e           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [31:0]      nonce_q, nonce_d;
    logic [31:0]      last_nonce_q, last_nonce_d;
    logic [255:0]     mid_q, mid_d;
    logic [95:0]      tail_q, tail_d;
    logic [767:0]     data_q, data_d;
    logic             stb_q, stb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SHA256_DISPATCH_RANGE_EN
    logic [31:0]      end_q, end_d;
`else
    logic             unused_end;
    assign unused_end = ^i_work_nonce_end;
`endif

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        nonce_d      = nonce_q;
        last_nonce_d = last_nonce_q;
        mid_d        = mid_q;
        tail_d       = tail_q;
        done_d       = 1'b0;
`ifdef SHA256_DISPATCH_RANGE_EN
        end_d        = end_q;
`endif
        if (state_q == ST_RUN) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        end
        // stb_q marks the cycle in which nonce_q is being issued.
        if (stb_q) begin
            last_nonce_d = nonce_q;
            nonce_d      = nonce_q + 32'd1;
`ifdef SHA256_DISPATCH_RANGE_EN
            if (nonce_q == end_q) begin
                state_d = ST_IDLE;
                phase_d = '0;
                done_d  = 1'b1;
            end
`endif
        end
        // A new job overrides both the running sweep and a pending done.
        if (i_work_stb) begin
            mid_d   = i_work_midstate;
            tail_d  = i_work_tail;
            nonce_d = i_work_nonce_start;
            phase_d = '0;
            state_d = ST_RUN;
            done_d  = 1'b0;
`ifdef SHA256_DISPATCH_RANGE_EN
            end_d   = i_work_nonce_end;
`endif
        end
        stb_d  = (state_d == ST_RUN) && (phase_d == '0);
        busy_d = (state_d == ST_RUN);
        data_d = (state_d == ST_RUN) ? build_block(mid_d, tail_d, nonce_d) : data_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_sync) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            nonce_q      <= '0;
            last_nonce_q <= '0;
            mid_q        <= '0;
            tail_q       <= '0;
            data_q       <= '0;
            stb_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SHA256_DISPATCH_RANGE_EN
            end_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            nonce_q      <= nonce_d;
            last_nonce_q <= last_nonce_d;
            mid_q        <= mid_d;
            tail_q       <= tail_d;
            data_q       <= data_d;
            stb_q        <= stb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SHA256_DISPATCH_RANGE_EN
            end_q        <= end_d;
`endif
        end
    end

    sha256_k_sequencer #(
        .P_UNWRAP_LEVEL (P_UNWRAP_LEVEL),
        .PH_W           (PH_W)
    ) u_k_seq (
        .phase_i (phase_q),
        .ks_o    (Ks)
    );

    assign o_master_write_stb  = stb_q;
    assign o_master_write_data = data_q;
    assign o_last_nonce        = last_nonce_q;
    assign o_busy              = busy_q;
    assign o_done              = done_q;

endmodule

// File: tb/tb_sha256_nonce_dispatcher.sv
// Bench for sha256_nonce_dispatcher: three unroll levels driven in parallel, each checked
// every cycle against an arithmetic model (strobe at offset multiples of P, nonce = start + offset/P).
module tb_sha256_nonce_dispatcher;

    localparam int PTAB [3] = '{32, 1, 2};
`ifdef SHA256_DISPATCH_RANGE_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    localparam logic [31:0] K_REF [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // clock / reset / stimulus signals
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         wstb = 1'b0;
    logic [255:0] mid = '0;
    logic [95:0]  tail = '0;
    logic [31:0]  ns = '0;
    logic [31:0]  ne = '0;

    logic         stb_w  [3];
    logic         busy_w [3];
    logic         done_w [3];
    logic [31:0]  last_w [3];
    logic [767:0] data_w [3];
    logic [63:0]   ks_a;
    logic [2047:0] ks_b;
    logic [1023:0] ks_c;

    sha256_nonce_dispatcher #(.P_UNWRAP_LEVEL(32)) u_p32 (
        .i_clk(clk), .i_reset_sync(rst), .i_work_stb(wstb), .i_work_midstate(mid),
        .i_work_tail(tail), .i_work_nonce_start(ns), .i_work_nonce_end(ne),
        .o_master_write_stb(stb_w[0]), .o_master_write_data(data_w[0]), .Ks(ks_a),
        .o_last_nonce(last_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]));

    sha256_nonce_dispatcher #(.P_UNWRAP_LEVEL(1)) u_p1 (
        .i_clk(clk), .i_reset_sync(rst), .i_work_stb(wstb), .i_work_midstate(mid),
        .i_work_tail(tail), .i_work_nonce_start(ns), .i_work_nonce_end(ne),
        .o_master_write_stb(stb_w[1]), .o_master_write_data(data_w[1]), .Ks(ks_b),
        .o_last_nonce(last_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]));

    sha256_nonce_dispatcher #(.P_UNWRAP_LEVEL(2)) u_p2 (
        .i_clk(clk), .i_reset_sync(rst), .i_work_stb(wstb), .i_work_midstate(mid),
        .i_work_tail(tail), .i_work_nonce_start(ns), .i_work_nonce_end(ne),
        .o_master_write_stb(stb_w[2]), .o_master_write_data(data_w[2]), .Ks(ks_c),
        .o_last_nonce(last_w[2]), .o_busy(busy_w[2]), .o_done(done_w[2]));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // reference model state, one entry per instance
    bit           m_act   [3];
    int unsigned  m_off   [3];
    logic [31:0]  m_start [3];
    logic [31:0]  m_end   [3];
    logic [255:0] m_mid   [3];
    logic [95:0]  m_tail  [3];
    logic [31:0]  m_last  [3];
    bit           m_done  [3];
    logic [767:0] m_data  [3];

    task automatic check_eq(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [767:0] ref_block(input logic [255:0] m, input logic [95:0] t,
                                               input logic [31:0] n);
        logic [511:0] w;
        w = '0;
        w[95:0]    = t;
        w[127:96]  = n;
        w[159:128] = 32'h80000000;
        w[511:480] = 32'h00000280;
        return {w, m};
    endfunction

    function automatic logic [2047:0] ks_of(input int p);
        case (p)
            0:       return {1984'd0, ks_a};
            1:       return ks_b;
            default: return {1024'd0, ks_c};
        endcase
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 3; p++) begin
            m_act[p] = 0; m_off[p] = 0; m_start[p] = '0; m_end[p] = '0;
            m_mid[p] = '0; m_tail[p] = '0; m_last[p] = '0; m_done[p] = 0; m_data[p] = '0;
        end
    endtask

    // Advance the model across one clock edge with inputs r / w.
    task automatic model_step(input logic r, input logic w);
        for (int p = 0; p < 3; p++) begin
            int unsigned pl;
            bit issuing;
            logic [31:0] cur;
            pl = PTAB[p];
            issuing = m_act[p] && (m_off[p] % pl == 0);
            cur = m_start[p] + 32'(m_off[p] / pl);
            if (r) begin
                m_act[p] = 0; m_off[p] = 0; m_start[p] = '0; m_end[p] = '0; m_mid[p] = '0;
                m_tail[p] = '0; m_last[p] = '0; m_done[p] = 0; m_data[p] = '0;
            end else begin
                m_done[p] = 0;
                if (issuing) m_last[p] = cur;
                if (w) begin
                    m_act[p] = 1; m_off[p] = 0; m_start[p] = ns; m_end[p] = ne;
                    m_mid[p] = mid; m_tail[p] = tail;
                end else if (m_act[p]) begin
                    if (RANGE_EN && issuing && cur == m_end[p]) begin
                        m_act[p] = 0; m_done[p] = 1;
                    end else begin
                        m_off[p]++;
                    end
                end
                if (m_act[p] && (m_off[p] % pl == 0))
                    m_data[p] = ref_block(m_mid[p], m_tail[p], m_start[p] + 32'(m_off[p] / pl));
            end
        end
    endtask

    task automatic check_all();
        for (int p = 0; p < 3; p++) begin
            int unsigned pl;
            int n;
            int ph;
            bit s;
            logic [2047:0] ks;
            string pre;
            pl = PTAB[p];
            n = 64 / PTAB[p];
            s = m_act[p] && (m_off[p] % pl == 0);
            ph = m_act[p] ? int'(m_off[p] % pl) : 0;
            pre = $sformatf("p%0d c%0d", PTAB[p], cyc);
            check_eq({pre, " stb"},  768'(stb_w[p]),  768'(s));
            check_eq({pre, " busy"}, 768'(busy_w[p]), 768'(m_act[p]));
            check_eq({pre, " done"}, 768'(done_w[p]), 768'(m_done[p]));
            check_eq({pre, " last"}, 768'(last_w[p]), 768'(m_last[p]));
            if (!m_act[p] || s)
                check_eq({pre, " data"}, data_w[p], m_data[p]);
            else
                check_eq({pre, " mid"}, 768'(data_w[p][255:0]), 768'(m_mid[p]));
            ks = ks_of(p);
            for (int i = 0; i < n; i++)
                check_eq($sformatf("%s ks%0d", pre, i), 768'(ks[(n-1-i)*32 +: 32]), 768'(K_REF[ph*n + i]));
        end
    endtask

    // driver: apply inputs for one cycle, advance model, then check after the edge
    task automatic tick(input logic r, input logic w, input logic [31:0] s, input logic [31:0] e);
        rst = r; wstb = w; ns = s; ne = e;
        if (w) begin
            for (int i = 0; i < 8; i++) mid[i*32 +: 32] = $urandom;
            for (int i = 0; i < 3; i++) tail[i*32 +: 32] = $urandom;
        end
        model_step(r, w);
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    initial begin
        int len;
        logic r, w;
        logic [31:0] s;
        model_reset();
        repeat (3) tick(1'b1, 1'b0, '0, '0);

        // range 0x10..0x12: strobes at cycles 1, 33, 65 for P=32
        cyc = 0;
        tick(1'b0, 1'b1, 32'h10, 32'h12);
        tick(1'b0, 1'b0, '0, '0);
        check_eq("p2 phase1 msb", 768'(ks_c[1023:992]), 768'(32'h27b70a85));
        repeat (70) tick(1'b0, 1'b0, '0, '0);

        // wrap through 0xFFFFFFFF
        tick(1'b0, 1'b1, 32'hFFFFFFFE, 32'h00000001);
        repeat (12) tick(1'b0, 1'b0, '0, '0);

        // reset asserted during the second P=32 strobe
        tick(1'b0, 1'b1, 32'h20, 32'h40);
        repeat (32) tick(1'b0, 1'b0, '0, '0);
        tick(1'b1, 1'b0, '0, '0);
        tick(1'b0, 1'b0, '0, '0);

        // new job coinciding with the final P=2 strobe
        tick(1'b0, 1'b1, 32'h5, 32'h6);
        tick(1'b0, 1'b0, '0, '0);
        tick(1'b0, 1'b0, '0, '0);
        tick(1'b0, 1'b1, 32'h100, 32'h101);
        repeat (8) tick(1'b0, 1'b0, '0, '0);

        // start == end
        tick(1'b0, 1'b1, 32'h5, 32'h5);
        repeat (70) tick(1'b0, 1'b0, '0, '0);

        // randomized jobs, resets and overlapping loads
        for (int it = 0; it < 20; it++) begin
            s = $urandom;
            tick(1'b0, 1'b1, s, s + 32'($urandom_range(0, 3)));
            len = $urandom_range(1, 100);
            for (int c = 0; c < len; c++) begin
                r = ($urandom_range(0, 49) == 0);
                w = !r && ($urandom_range(0, 39) == 0);
                s = $urandom;
                tick(r, w, s, s + 32'($urandom_range(0, 3)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
